// File: rtl/simon_pkg.sv
// Shared state encoding, colour type, one-hot decode and LFSR constants for the Simon sequencer.
// Pure declarations: no logic, no latency, no flow control.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXTEND,
        SHOW_ON,
        SHOW_OFF,
        WAIT_INPUT,
        CHECK,
        WIN,
        LOSE
    } state_t;

    typedef logic [1:0] colour_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [3:0] onehot(input colour_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, stepping every cycle from the fixed seed.
// New value one cycle after each edge; no backpressure, never stalls.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random colour sequence, plays it back, then checks the player's entries.
// Outputs decode directly from state each cycle; inputs arriving outside their accepting states are dropped.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int ON_TICKS  = 25_000_000,
    parameter int OFF_TICKS = 12_500_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         press_valid,
    input  logic                         correct_input,
    output logic [3:0]                   led,
    output logic [3:0]                   actual,
    output logic                         on_off,
    output logic [$clog2(MAX_LEN+1)-1:0] level,
    output logic                         win,
    output logic                         lose,
    output logic                         busy
);

    localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TW        = (MAX_TICKS > 2) ? $clog2(MAX_TICKS) : 1;
    localparam int IW        = $clog2(MAX_LEN);
    localparam int LW        = $clog2(MAX_LEN + 1);

    state_t         r_state, w_state_nxt;
    logic [LW-1:0]  r_length, w_length_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic [TW-1:0]  r_timer, w_timer_nxt;
    colour_t        r_mem [MAX_LEN];
    colour_t        w_cur;
    logic [15:0]    w_lfsr;
    logic           w_unused_lfsr;
    logic           w_idx_last;
    logic           w_full;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:2];
    assign w_cur         = r_mem[r_idx];
    assign w_idx_last    = (LW'(r_idx) + LW'(1)) == r_length;
    assign w_full        = r_length == LW'(MAX_LEN);
    assign level         = r_length;

    // Sequence storage carries no reset: entries at or above length are never read.
    always_ff @(posedge clk) begin
        if (r_state == EXTEND) begin
            r_mem[r_length[IW-1:0]] <= w_lfsr[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_length <= '0;
            r_idx    <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_length <= w_length_nxt;
            r_idx    <= w_idx_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_length_nxt = r_length;
        w_idx_nxt    = r_idx;
        w_timer_nxt  = r_timer;
        case (r_state)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    w_length_nxt = '0;
                    w_state_nxt  = EXTEND;
                end
            end
            EXTEND: begin
                w_length_nxt = r_length + LW'(1);
                w_idx_nxt    = '0;
                w_timer_nxt  = '0;
                w_state_nxt  = SHOW_ON;
            end
            SHOW_ON: begin
                if (r_timer == TW'(ON_TICKS - 1)) begin
                    w_timer_nxt = '0;
                    w_state_nxt = SHOW_OFF;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            SHOW_OFF: begin
                if (r_timer == TW'(OFF_TICKS - 1)) begin
                    w_timer_nxt = '0;
                    if (w_idx_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = WAIT_INPUT;
                    end else begin
                        w_idx_nxt   = r_idx + IW'(1);
                        w_state_nxt = SHOW_ON;
                    end
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            WAIT_INPUT: begin
                if (press_valid) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!correct_input) begin
                    w_state_nxt = LOSE;
                end else if (!w_idx_last) begin
                    w_idx_nxt   = r_idx + IW'(1);
                    w_state_nxt = WAIT_INPUT;
                end else if (w_full) begin
                    w_state_nxt = WIN;
                end else begin
                    w_state_nxt = EXTEND;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        led    = '0;
        actual = '0;
        on_off = 1'b0;
        win    = 1'b0;
        lose   = 1'b0;
        busy   = 1'b1;
        case (r_state)
            IDLE:    busy = 1'b0;
            SHOW_ON: led  = onehot(w_cur);
            WAIT_INPUT, CHECK: begin
                on_off = 1'b1;
                actual = onehot(w_cur);
            end
            WIN: begin
                busy = 1'b0;
                win  = 1'b1;
                led  = 4'b1111;
            end
            LOSE: begin
                busy = 1'b0;
                lose = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Randomised scoreboard bench for simon_sequencer with short playback timing and a 3-colour game.
module tb_simon_sequencer;

    localparam int ML  = 3;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int PER = ON + OFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       press_valid = 1'b0;
    logic       correct_input = 1'b0;
    logic [3:0] led;
    logic [3:0] actual;
    logic       on_off;
    logic [1:0] level;
    logic       win;
    logic       lose;
    logic       busy;

    simon_sequencer #(
        .MAX_LEN   (ML),
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .start         (start),
        .press_valid   (press_valid),
        .correct_input (correct_input),
        .led           (led),
        .actual        (actual),
        .on_off        (on_off),
        .level         (level),
        .win           (win),
        .lose          (lose),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          seq[$];
    logic [3:0]  exp_q[$];
    int          cur_idx = 0;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // Reference LFSR value: step^n(seed) after n clock edges out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic push_round();
        foreach (seq[i]) exp_q.push_back(4'b0001 << seq[i]);
    endtask

    // Monitor: collects each lit playback flash and scores it against the queue.
    int         run_len = 0;
    logic [3:0] run_led = '0;
    logic [3:0] exp_led;
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (led != 4'h0 && led != 4'hF) begin
            if (run_len == 0) run_led = led;
            else check("flash_stable", led, run_led);
            run_len++;
            check("flash_onoff", on_off, 0);
            check("flash_actual", actual, 0);
        end else if (run_len > 0) begin
            if (exp_q.size() == 0) begin
                check("flash_unexpected", run_led, 0);
            end else begin
                exp_led = exp_q.pop_front();
                check("flash_led", run_led, exp_led);
                check("flash_len", run_len, ON);
            end
            run_len = 0;
        end
    end

    task automatic wait_play(input int k0, input int exp_k);
        int k;
        k = k0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            k++;
            if (on_off) break;
            press_valid = ($urandom_range(0, 3) == 0);
        end
        press_valid = 1'b0;
        check("play_cycles", k, exp_k);
        check("wait_level", level, seq.size());
        check("wait_busy", busy, 1);
        check("wait_led", led, 0);
    endtask

    task automatic do_start();
        logic [15:0] nx;
        nx = lfsr_step(m_lfsr);
        seq.delete();
        seq.push_back(int'(nx[1:0]));
        cur_idx = 0;
        push_round();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_win", win, 0);
        check("start_lose", lose, 0);
        check("start_level", level, 0);
        check("start_busy", busy, 1);
        wait_play(1, 2 + PER);
    endtask

    task automatic do_press(input bit good);
        logic [15:0] nx;
        logic [3:0]  a;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            check("dwell_onoff", on_off, 1);
        end
        a = 4'b0001 << seq[cur_idx];
        check("wait_actual", actual, a);
        nx = lfsr_step(lfsr_step(m_lfsr));
        press_valid   = 1'b1;
        correct_input = good;
        @(posedge clk); #1;
        press_valid = 1'b0;
        check("check_onoff", on_off, 1);
        check("check_actual", actual, a);
        @(posedge clk); #1;
        correct_input = 1'b0;
        if (!good) begin
            check("lose_flag", lose, 1);
            check("lose_onoff", on_off, 0);
            check("lose_busy", busy, 0);
            check("lose_win", win, 0);
        end else if (cur_idx < seq.size() - 1) begin
            cur_idx++;
        end else if (seq.size() == ML) begin
            check("win_flag", win, 1);
            check("win_led", led, 4'hF);
            check("win_busy", busy, 0);
            check("win_level", level, ML);
        end else begin
            seq.push_back(int'(nx[1:0]));
            cur_idx = 0;
            push_round();
            wait_play(2, 3 + PER * seq.size());
        end
    endtask

    task automatic tail_check(input bit won);
        int lv;
        lv = seq.size();
        for (int n = 0; n < 4; n++) begin
            press_valid   = n[0];
            correct_input = 1'b1;
            @(posedge clk); #1;
            check("sticky_win", win, won);
            check("sticky_lose", lose, !won);
            check("sticky_onoff", on_off, 0);
            check("sticky_led", led, won ? 4'hF : 4'h0);
            check("sticky_level", level, lv);
        end
        press_valid   = 1'b0;
        correct_input = 1'b0;
    endtask

    task automatic play_game(input int fail_round, input int fail_idx);
        bit ok;
        do_start();
        for (int r = 1; r <= ML; r++) begin
            for (int i = 0; i < r; i++) begin
                ok = !(r == fail_round && i == fail_idx);
                do_press(ok);
                if (!ok) begin
                    tail_check(1'b0);
                    return;
                end
            end
        end
        tail_check(1'b1);
    endtask

    task automatic reset_mid_show();
        logic [15:0] nx;
        logic [3:0]  c;
        nx = lfsr_step(m_lfsr);
        c  = 4'b0001 << nx[1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("pre_reset_led", led, c);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_led", led, 0);
        check("rst_actual", actual, 0);
        check("rst_onoff", on_off, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_win", win, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        check("post_rst_busy", busy, 0);
        check("post_rst_led", led, 0);
        check("post_rst_level", level, 0);
    endtask

    initial begin
        int fr;
        #1 rst_n = 1'b0;
        #2;
        check("reset_led", led, 0);
        check("reset_actual", actual, 0);
        check("reset_onoff", on_off, 0);
        check("reset_win", win, 0);
        check("reset_lose", lose, 0);
        check("reset_busy", busy, 0);
        check("reset_level", level, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat ($urandom_range(1, 5)) begin @(posedge clk); #1; end
        press_valid = 1'b1;
        @(posedge clk); #1;
        press_valid = 1'b0;
        check("idle_press_busy", busy, 0);
        check("idle_press_onoff", on_off, 0);

        play_game(0, 0);
        play_game(2, $urandom_range(0, 1));
        reset_mid_show();
        play_game(0, 0);
        for (int g = 0; g < 4; g++) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            fr = $urandom_range(0, 3);
            play_game(fr, (fr == 0) ? 0 : $urandom_range(0, fr - 1));
        end

        repeat (2) begin @(posedge clk); #1; end
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning the maximum sequence length and the winning level.
REQ-002 SHALL have parameter ON_TICKS, default 25_000_000, meaning the clk cycles each playback LED is lit.
REQ-003 SHALL have parameter OFF_TICKS, default 12_500_000, meaning the clk cycles of blank gap after each playback LED.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle pulse that begins a new game.
REQ-007 SHALL have port press_valid, input, 1 bit: one-cycle pulse meaning the player has entered sw.
REQ-008 SHALL have port correct_input, input, 1 bit: comparator result (registered compare of sw against actual).
REQ-009 SHALL have port led, output, 4 bits: one-hot playback display.
REQ-010 SHALL have port actual, output, 4 bits: one-hot expected colour presented to the comparator.
REQ-011 SHALL have port on_off, output, 1 bit: comparator enable, high only while waiting for input.
REQ-012 SHALL have port level, output, $clog2(MAX_LEN+1) bits: current sequence length.
REQ-013 SHALL have ports win, lose and busy, each output, 1 bit: game status flags.

Function
REQ-014 SHALL implement states IDLE, EXTEND, SHOW_ON, SHOW_OFF, WAIT_INPUT, CHECK, WIN, LOSE.
REQ-015 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that steps every cycle in all states; new colour = lfsr[1:0].
REQ-016 SHALL map colour c to one-hot 4'b0001 << c for led and actual.
REQ-017 SHALL, on start in IDLE, WIN or LOSE, clear length, win and lose, then enter EXTEND; start in any other state is ignored.
REQ-018 SHALL, in EXTEND (one cycle), write mem[length] <= lfsr[1:0], increment length, clear idx and timer, then enter SHOW_ON.
REQ-019 SHALL, in SHOW_ON, drive led = onehot(mem[idx]) for exactly ON_TICKS cycles, then enter SHOW_OFF.
REQ-020 SHALL, in SHOW_OFF, drive led = 0 for exactly OFF_TICKS cycles; then, if idx == length-1, clear idx and enter WAIT_INPUT, else increment idx and enter SHOW_ON.
REQ-021 SHALL, in WAIT_INPUT, drive on_off = 1, actual = onehot(mem[idx]) and led = 0; press_valid moves to CHECK.
REQ-022 SHALL ignore press_valid in every state except WAIT_INPUT.
REQ-023 SHALL, in CHECK (one cycle, the cycle after press_valid), keep on_off = 1 and actual unchanged, and sample correct_input.
REQ-024 SHALL, in CHECK, go to LOSE if correct_input = 0.
REQ-025 SHALL, in CHECK with correct_input = 1 and idx < length-1, increment idx and return to WAIT_INPUT.
REQ-026 SHALL, in CHECK with correct_input = 1 and idx == length-1, go to WIN if length == MAX_LEN, else to EXTEND.
REQ-027 SHALL, in WIN, hold win = 1 and led = 4'b1111; in LOSE, hold lose = 1 and led = 0; both are sticky until start.
REQ-028 SHALL drive on_off = 0 and actual = 0 in every state except WAIT_INPUT and CHECK.
REQ-029 SHALL drive busy = 1 in every state except IDLE, WIN and LOSE.
REQ-030 SHALL drive level = length at all times.
REQ-031 SHALL size timer to $clog2(max(ON_TICKS, OFF_TICKS)) bits and idx to $clog2(MAX_LEN) bits; length never exceeds MAX_LEN.

Reset
REQ-032 SHALL, on reset = 0, immediately force state IDLE, length = 0, idx = 0, timer = 0, LFSR = seed, and led, actual, on_off, win, lose and busy all 0, including mid-playback or mid-input.
REQ-033 SHALL leave sequence memory contents unreset; contents are don't-care because length = 0.

Structure
REQ-034 SHALL place the state enum, the 2-bit colour typedef, the onehot function, and the LFSR seed and tap constants in shared package simon_pkg.
REQ-035 SHALL implement the LFSR as sub-module simon_lfsr (ports clk, reset, q[15:0]).

Verification (ON_TICKS=4, OFF_TICKS=2, MAX_LEN=3)
REQ-036 Reset then start -> after EXTEND, led one-hot for 4 cycles, then 0 for 2 cycles, then on_off = 1, level = 1.
REQ-037 In WAIT_INPUT, press_valid with correct_input = 1 on the next cycle, at level 1 -> EXTEND, level = 2, replay of 2 colours with mem[0] unchanged.
REQ-038 correct_input = 0 in CHECK -> lose = 1, on_off = 0, busy = 0; further press_valid pulses have no effect.
REQ-039 Three fully correct rounds -> win = 1, led = 4'b1111, level = 3; start then gives level = 1 and win = 0.
REQ-040 press_valid during SHOW_ON -> ignored; playback timing unchanged and on_off stays 0.
REQ-041 reset asserted mid-SHOW_ON -> all outputs 0 within the same cycle; state IDLE after release.
